// File: rtl/sh4_fpu_lzc_pipe_if.sv
// ---------------------------------------------------------------------------
// sh4_fpu_lzc_pipe_if
// Handshake and data bundle for the FPU leading/trailing-zero normaliser.
//
// Parameters:
//   WIDTH : operand width
//   TAGW  : width of the opaque sideband tag
//
// Signals:
//   in_valid / in_ready            : operand handshake (producer -> block)
//   in_data, in_mode, in_tag       : operand, 0 = CLZ / 1 = CTZ, sideband tag
//   out_valid / out_ready          : result handshake (block -> consumer)
//   out_count, out_zero            : zero count (CW bits), operand-was-zero flag
//   out_norm, out_tag              : shifted operand, returned tag
//   in_limit / out_limited         : shift clamp and clamp-hit flag, present
//                                    only when SH4_FPU_LZC_LIMIT_EN is defined
//
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the normaliser itself
// ---------------------------------------------------------------------------
interface sh4_fpu_lzc_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic [WIDTH-1:0] out_norm;
  logic [TAGW-1:0]  out_tag;
`ifdef SH4_FPU_LZC_LIMIT_EN
  logic [CW-1:0]    in_limit;
  logic             out_limited;
`endif

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
`ifdef SH4_FPU_LZC_LIMIT_EN
    output in_limit,
    input  out_limited,
`endif
    input  in_ready, out_valid, out_count, out_zero, out_norm, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
`ifdef SH4_FPU_LZC_LIMIT_EN
    input  in_limit,
    output out_limited,
`endif
    output in_ready, out_valid, out_count, out_zero, out_norm, out_tag
  );
endinterface

// File: rtl/sh4_fpu_lzc_pipe.sv
// ---------------------------------------------------------------------------
// sh4_fpu_lzc_pipe
// Two-stage pipelined leading/trailing-zero counter and normaliser used
// between the mantissa adder/multiplier and the rounder, and for FLOAT/FTRC
// and denormal handling.
//
// Parameters:
//   WIDTH : operand width (2..64)
//   TAGW  : sideband tag width
//   GROUP : bits per stage-1 sub-block, must divide WIDTH
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : sh4_fpu_lzc_pipe_if.slave -- operand handshake in, result
//          handshake out (see the interface file for the signal list)
//
// Optional feature (macro SH4_FPU_LZC_LIMIT_EN):
//   Adds bus.in_limit / bus.out_limited. The applied shift becomes
//   min(count, in_limit), out_count reports that applied shift and
//   out_limited flags that the clamp was hit. out_zero still reflects the
//   raw operand.
//
// Timing: an operand accepted on one edge sits in S1 after it and in S2
// (driving the outputs) after the next, one result per cycle when the
// consumer is always ready; a stalled pipeline holds two operands.
// ---------------------------------------------------------------------------
module sh4_fpu_lzc_pipe #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4,
  parameter int GROUP = 8
) (
  input logic             clk,
  input logic             rst,
  sh4_fpu_lzc_pipe_if.slave bus
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int NB  = WIDTH / GROUP;
  localparam int GCW = $clog2(GROUP + 1);

  // Stage 1 state
  logic                      s1_valid;
  logic [NB-1:0][GCW-1:0]    s1_cnt;
  logic [NB-1:0]             s1_nz;
  logic [WIDTH-1:0]          s1_data;
  logic                      s1_mode;
  logic [TAGW-1:0]           s1_tag;
`ifdef SH4_FPU_LZC_LIMIT_EN
  logic [CW-1:0]             s1_limit;
  logic                      s2_limited;
`endif

  // Stage 2 state (drives the outputs directly)
  logic                      s2_valid;
  logic [CW-1:0]             s2_count;
  logic                      s2_zero;
  logic [WIDTH-1:0]          s2_norm;
  logic [TAGW-1:0]           s2_tag;

  // Combinational helpers
  logic [NB-1:0][GCW-1:0]    blk_cnt;
  logic [NB-1:0]             blk_nz;
  logic [CW-1:0]             raw_cnt;
  logic [CW-1:0]             shift;
  logic                      limited;
  logic [WIDTH-1:0]          norm;
  logic                      s1_adv;
  logic                      s2_adv;

  // Each stage moves when the stage after it is empty or emptying, so a
  // draining S2 and a loading S1 can happen on the same edge.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !rst;

  // Per-block local counts. Later loop iterations override earlier ones, so
  // scanning upward leaves the highest set bit (CLZ) and scanning downward
  // leaves the lowest set bit (CTZ). An all-zero block reports GROUP, but its
  // count is never selected because its nonzero flag is clear.
  always_comb begin
    blk_cnt = '0;
    blk_nz  = '0;
    for (int b = 0; b < NB; b++) begin
      blk_nz[b]  = |bus.in_data[b*GROUP +: GROUP];
      blk_cnt[b] = GCW'(GROUP);
      if (bus.in_mode) begin
        for (int i = GROUP - 1; i >= 0; i--) begin
          if (bus.in_data[b*GROUP + i]) blk_cnt[b] = GCW'(i);
        end
      end else begin
        for (int i = 0; i < GROUP; i++) begin
          if (bus.in_data[b*GROUP + i]) blk_cnt[b] = GCW'(GROUP - 1 - i);
        end
      end
    end
  end

  // Stage 2 combine: the first nonzero block from the MSB end (CLZ) or the
  // LSB end (CTZ) contributes its local count plus the width of all the
  // all-zero blocks in front of it. No nonzero block means count = WIDTH.
  always_comb begin
    raw_cnt = CW'(WIDTH);
    if (s1_mode) begin
      for (int b = NB - 1; b >= 0; b--) begin
        if (s1_nz[b]) raw_cnt = CW'(b * GROUP) + CW'(s1_cnt[b]);
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (s1_nz[b]) raw_cnt = CW'((NB - 1 - b) * GROUP) + CW'(s1_cnt[b]);
      end
    end

    shift   = raw_cnt;
    limited = 1'b0;
`ifdef SH4_FPU_LZC_LIMIT_EN
    // A zero operand has raw count WIDTH, so this also flags in_limit < WIDTH
    // for zero data.
    if (raw_cnt > s1_limit) begin
      shift   = s1_limit;
      limited = 1'b1;
    end
`endif

    // A zero operand shifts to zero in either direction, so no special case.
    if (s1_mode) norm = s1_data >> shift;
    else         norm = s1_data << shift;
  end

  // Stage 1 register: loads only on an accepted operand, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_nz    <= '0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
      s1_tag   <= '0;
`ifdef SH4_FPU_LZC_LIMIT_EN
      s1_limit <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_cnt   <= blk_cnt;
        s1_nz    <= blk_nz;
        s1_data  <= bus.in_data;
        s1_mode  <= bus.in_mode;
        s1_tag   <= bus.in_tag;
`ifdef SH4_FPU_LZC_LIMIT_EN
        s1_limit <= bus.in_limit;
`endif
      end
    end
  end

  // Stage 2 register: result fields only change when a new S1 entry moves
  // in, which keeps the outputs stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_count   <= '0;
      s2_zero    <= 1'b0;
      s2_norm    <= '0;
      s2_tag     <= '0;
`ifdef SH4_FPU_LZC_LIMIT_EN
      s2_limited <= 1'b0;
`endif
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_count   <= shift;
        s2_zero    <= ~|s1_nz;
        s2_norm    <= norm;
        s2_tag     <= s1_tag;
`ifdef SH4_FPU_LZC_LIMIT_EN
        s2_limited <= limited;
`endif
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_count   = s2_count;
  assign bus.out_zero    = s2_zero;
  assign bus.out_norm    = s2_norm;
  assign bus.out_tag     = s2_tag;
`ifdef SH4_FPU_LZC_LIMIT_EN
  assign bus.out_limited = s2_limited;
`endif

endmodule

// File: tb/tb_sh4_fpu_lzc_pipe.sv
// ---------------------------------------------------------------------------
// tb_sh4_fpu_lzc_pipe
// Self-checking bench for sh4_fpu_lzc_pipe (WIDTH=32, TAGW=4, GROUP=8).
// Directed operands from the test plan followed by randomized traffic with
// random valid/backpressure. Expected results come from an arithmetic model
// (highest/lowest set bit via $clog2) and a queue of in-flight operands.
// Honours SH4_FPU_LZC_LIMIT_EN when defined.
// ---------------------------------------------------------------------------
module tb_sh4_fpu_lzc_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic [CW-1:0] cnt;
    logic          zero;
    logic [W-1:0]  norm;
    logic [TW-1:0] tag;
    logic          limited;
    int            readyStep;
  } expect_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   stepNum;
  expect_t expQ[$];

  sh4_fpu_lzc_pipe_if #(.WIDTH(W), .TAGW(TW)) bus ();

  sh4_fpu_lzc_pipe #(.WIDTH(W), .TAGW(TW), .GROUP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (step %0d)",
               name, got, exp, stepNum);
    end
  endtask

  // Reference: highest set bit index = $clog2(v+1)-1, lowest set bit is the
  // index of the isolated bit v & -v.
  function automatic expect_t model(input logic [W-1:0] d, input logic m,
                                    input logic [TW-1:0] t,
                                    input logic [CW-1:0] lim);
    expect_t e;
    longint unsigned v;
    longint unsigned r;
    int raw;
    int sh;
    v = 64'(d);
    if (v == 0)  raw = W;
    else if (!m) raw = W - $clog2(v + 1);
    else         raw = $clog2(v & (~v + 1));
    sh = raw;
    e.limited = 1'b0;
    if (raw > int'(lim)) begin
      sh = int'(lim);
      e.limited = 1'b1;
    end
    r = m ? (v >> sh) : (v << sh);
    e.cnt  = CW'(sh);
    e.zero = (v == 0);
    e.norm = r[W-1:0];
    e.tag  = t;
    e.readyStep = 0;
    return e;
  endfunction

  function automatic logic [CW-1:0] pickLimit();
`ifdef SH4_FPU_LZC_LIMIT_EN
    if ($urandom_range(0, 2) == 0) return CW'($urandom_range(0, W));
`endif
    return CW'(W);
  endfunction

  // One cycle: drive inputs after the falling edge, let them settle, then
  // check handshake and result against the model and update the model for
  // the transfers that the coming rising edge will perform.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic m, input logic [TW-1:0] t,
                               input logic ordy, input logic [CW-1:0] lim);
    logic expReady;
    logic expValid;
    expect_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.in_tag    = t;
    bus.out_ready = ordy;
`ifdef SH4_FPU_LZC_LIMIT_EN
    bus.in_limit  = lim;
`endif
    #1;
    expReady = (expQ.size() < 2) || ordy;
    expValid = (expQ.size() > 0) && (expQ[0].readyStep <= stepNum);
    checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
    if (expValid) begin
      checkOutput("out_count", 64'(bus.out_count), 64'(expQ[0].cnt));
      checkOutput("out_zero", 64'(bus.out_zero), 64'(expQ[0].zero));
      checkOutput("out_norm", 64'(bus.out_norm), 64'(expQ[0].norm));
      checkOutput("out_tag", 64'(bus.out_tag), 64'(expQ[0].tag));
`ifdef SH4_FPU_LZC_LIMIT_EN
      checkOutput("out_limited", 64'(bus.out_limited), 64'(expQ[0].limited));
`endif
      if (ordy) void'(expQ.pop_front());
    end
    if (v && expReady) begin
      e = model(d, m, t, lim);
      e.readyStep = stepNum + 2;
      expQ.push_back(e);
    end
    stepNum++;
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      #1;
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    #1;
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("post_rst_count", 64'(bus.out_count), 64'd0);
    checkOutput("post_rst_zero", 64'(bus.out_zero), 64'd0);
    checkOutput("post_rst_norm", 64'(bus.out_norm), 64'd0);
    checkOutput("post_rst_tag", 64'(bus.out_tag), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, CW'(W));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() > 0; i++) idle(1);
    checkOutput("drain_left", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         m;
    logic [CW-1:0] lnone;
    checks  = 0;
    errors  = 0;
    stepNum = 0;
    lnone   = CW'(W);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
`ifdef SH4_FPU_LZC_LIMIT_EN
    bus.in_limit  = '0;
`endif
    applyReset(3);

    // Basic CLZ/CTZ and all-zero operands
    applyStimulus(1'b1, 32'h00F0_0000, 1'b0, 4'd3, 1'b1, lnone);
    idle(3);
    applyStimulus(1'b1, 32'h0000_0A00, 1'b1, 4'd5, 1'b1, lnone);
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 4'd6, 1'b1, lnone);
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 4'd7, 1'b1, lnone);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 4'd8, 1'b1, lnone);
    idle(3);

    // Back-to-back stream, no bubbles
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'd1, 1'b1, lnone);
    applyStimulus(1'b1, 32'h0000_0001, 1'b0, 4'd2, 1'b1, lnone);
    applyStimulus(1'b1, 32'h0001_0000, 1'b0, 4'd3, 1'b1, lnone);
    idle(3);

    // Backpressure: three offers, two accepted, outputs held, then release
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 4'd9, 1'b0, lnone);
    applyStimulus(1'b1, 32'h0800_0000, 1'b1, 4'd10, 1'b0, lnone);
    applyStimulus(1'b1, 32'h0000_0003, 1'b0, 4'd11, 1'b0, lnone);
    applyStimulus(1'b1, 32'h0000_0003, 1'b0, 4'd11, 1'b0, lnone);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, lnone);
    drain();

    // Reset with both stages full, then a fresh operand
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 4'd12, 1'b0, lnone);
    applyStimulus(1'b1, 32'h0000_8000, 1'b1, 4'd13, 1'b0, lnone);
    applyReset(2);
    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 4'd14, 1'b1, lnone);
    idle(3);

`ifdef SH4_FPU_LZC_LIMIT_EN
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 4'd1, 1'b1, CW'(10));
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 4'd2, 1'b1, CW'(31));
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 4'd3, 1'b1, CW'(5));
    idle(3);
`endif

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      m = 1'(($urandom() & 32'h1));
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = W'(32'h1 << $urandom_range(0, W - 1));
        2:       d = m ? W'($urandom() << $urandom_range(0, W - 1))
                       : W'($urandom() >> $urandom_range(0, W - 1));
        default: d = W'($urandom());
      endcase
      applyStimulus(1'(($urandom_range(0, 9) < 7)), d, m, TW'($urandom()),
                    1'(($urandom_range(0, 9) < 6)), pickLimit());
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
